// File: rtl/ysyx_22050612_rf_read_stage_pkg.sv
// Shared register-file constants for the read stage, the register file and decode.
package ysyx_22050612_rf_read_stage_pkg;

   localparam int ADDR_WIDTH_DEF = 5;
   localparam int DATA_WIDTH_DEF = 64;
   localparam int NREG_DEF       = 2 ** ADDR_WIDTH_DEF;
   localparam int X0_IDX         = 0;

endpackage

// File: rtl/ysyx_22050612_rf_read_stage_if.sv
// Decode-request, write-back and execute-side handshake bundle of the register read stage.
interface ysyx_22050612_rf_read_stage_if
   import ysyx_22050612_rf_read_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_rs1;
   logic [ADDR_WIDTH-1:0] in_rs2;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_rd_wen;

   logic                  wb_wen;
   logic [ADDR_WIDTH-1:0] wb_waddr;
   logic [DATA_WIDTH-1:0] wb_wdata;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_src1;
   logic [DATA_WIDTH-1:0] out_src2;
   logic [ADDR_WIDTH-1:0] out_rd;
   logic                  out_rd_wen;

   // master: decode/write-back/execute environment; slave: the read stage
   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
      output wb_wen, wb_waddr, wb_wdata,
      output out_ready,
      input  in_ready, out_valid, out_src1, out_src2, out_rd, out_rd_wen
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
      input  wb_wen, wb_waddr, wb_wdata,
      input  out_ready,
      output in_ready, out_valid, out_src1, out_src2, out_rd, out_rd_wen
   );

endinterface

// File: rtl/ysyx_22050612_scoreboard.sv
// Pending-write scoreboard: one bit per register, cleared by write-back, set on issue.
module ysyx_22050612_scoreboard
   import ysyx_22050612_rf_read_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   localparam int NREG      = 2 ** ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [ADDR_WIDTH-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [ADDR_WIDTH-1:0] clr_idx,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] rd,
   output logic                  pend_rs1,
   output logic                  pend_rs2,
   output logic                  pend_rd,
   output logic [NREG-1:0]       pending
);

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;

   always_comb begin
      // NOTE: start from the held value so every path assigns pending_d and no latch is inferred.
      pending_d = pending_q;
      if (clr_en) pending_d[clr_idx] = 1'b0;
      // A same-cycle issue to the register being written back leaves it pending.
      if (set_en) pending_d[set_idx] = 1'b1;
      pending_d[X0_IDX] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the pending vector is control state, not data storage, so it must be reset.
      if (!rst_n) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign pend_rs1 = pending_q[rs1];
   assign pend_rs2 = pending_q[rs2];
   assign pend_rd  = pending_q[rd];
   assign pending  = pending_q;

endmodule

// File: rtl/ysyx_22050612_rf_read_stage.sv
// Register read stage: operand fetch with write-back bypass, hazard stall and one pipeline register.
module ysyx_22050612_rf_read_stage
   import ysyx_22050612_rf_read_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   localparam int NREG      = 2 ** ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH*NREG-1:0] rf_flat,
   ysyx_22050612_rf_read_stage_if.slave bus,
   output logic [NREG-1:0]            pending
);

   localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

   logic [DATA_WIDTH-1:0] src1;
   logic [DATA_WIDTH-1:0] src2;
   logic pend_rs1, pend_rs2, pend_rd;
   logic clr_rs1, clr_rs2, clr_rd;
   logic hazard_rs1, hazard_rs2, waw;
   logic accept;

   // x0 reads as zero and is never bypassed; write-back data wins over the array.
   function automatic logic [DATA_WIDTH-1:0] read_operand(
      input logic [ADDR_WIDTH-1:0]      idx,
      input logic [DATA_WIDTH*NREG-1:0] rf,
      input logic                       wen,
      input logic [ADDR_WIDTH-1:0]      waddr,
      input logic [DATA_WIDTH-1:0]      wdata
   );
      if (idx == X0)                return '0;
      if (wen && (waddr == idx))    return wdata;
      return rf[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   assign src1 = read_operand(bus.in_rs1, rf_flat, bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
   assign src2 = read_operand(bus.in_rs2, rf_flat, bus.wb_wen, bus.wb_waddr, bus.wb_wdata);

   assign clr_rs1 = bus.wb_wen && (bus.wb_waddr == bus.in_rs1);
   assign clr_rs2 = bus.wb_wen && (bus.wb_waddr == bus.in_rs2);
   assign clr_rd  = bus.wb_wen && (bus.wb_waddr == bus.in_rd);

   assign hazard_rs1 = pend_rs1 && !clr_rs1;
   assign hazard_rs2 = pend_rs2 && !clr_rs2;
   assign waw        = bus.in_rd_wen && (bus.in_rd != X0) && pend_rd && !clr_rd;

   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard_rs1 && !hazard_rs2 && !waw;
   assign accept       = bus.in_valid && bus.in_ready;

   ysyx_22050612_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (accept && bus.in_rd_wen),
      .set_idx  (bus.in_rd),
      .clr_en   (bus.wb_wen),
      .clr_idx  (bus.wb_waddr),
      .rs1      (bus.in_rs1),
      .rs2      (bus.in_rs2),
      .rd       (bus.in_rd),
      .pend_rs1 (pend_rs1),
      .pend_rs2 (pend_rs2),
      .pend_rd  (pend_rd),
      .pending  (pending)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.out_src1   <= '0;
         bus.out_src2   <= '0;
         bus.out_rd     <= '0;
         bus.out_rd_wen <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         bus.out_valid  <= 1'b1;
         bus.out_src1   <= src1;
         bus.out_src2   <= src2;
         bus.out_rd     <= bus.in_rd;
         bus.out_rd_wen <= bus.in_rd_wen;
      end else if (bus.out_ready) begin
         bus.out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_rf_read_stage.sv
// Self-checking bench for the register read stage against a per-register pending/array model.
module tb_ysyx_22050612_rf_read_stage;
   import ysyx_22050612_rf_read_stage_pkg::*;

   localparam int AW = ADDR_WIDTH_DEF;
   localparam int DW = DATA_WIDTH_DEF;
   localparam int NR = NREG_DEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [DW*NR-1:0]  rf_flat;
   logic [NR-1:0]     pending;
   logic [DW-1:0]     rf [NR];

   always_comb begin
      rf_flat = '0;
      for (int i = 0; i < NR; i++) rf_flat[i*DW +: DW] = rf[i];
   end

   ysyx_22050612_rf_read_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ysyx_22050612_rf_read_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rf_flat (rf_flat),
      .bus     (bus),
      .pending (pending)
   );

   // Reference model: which registers have an outstanding write, and what execute should see.
   bit            m_pend [NR];
   bit            m_valid;
   logic [DW-1:0] m_src1, m_src2;
   int            m_rd;
   bit            m_rd_wen;

   int n_checks = 0;
   int n_fail   = 0;
   logic last_ready;

   function automatic logic [NR-1:0] m_pend_vec();
      logic [NR-1:0] v = '0;
      for (int i = 1; i < NR; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic bit wb_hits(int idx);
      return bus.wb_wen && (int'(bus.wb_waddr) == idx);
   endfunction

   function automatic logic [DW-1:0] m_read(int idx);
      if (idx == 0)     return '0;
      if (wb_hits(idx)) return bus.wb_wdata;
      return rf[idx];
   endfunction

   function automatic bit m_blocked(int idx);
      return (idx != 0) && m_pend[idx] && !wb_hits(idx);
   endfunction

   function automatic bit m_ready(int rs1, int rs2, int rd, bit rd_wen);
      return !(m_valid && !bus.out_ready) && !m_blocked(rs1) && !m_blocked(rs2)
             && !(rd_wen && m_blocked(rd));
   endfunction

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_valid = 1'b0; m_src1 = '0; m_src2 = '0; m_rd = 0; m_rd_wen = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_rd_wen = 1'b0;
      bus.wb_wen = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0; bus.out_ready = 1'b1;
   endtask

   // One clock: drive, compare in_ready before the edge, advance, compare all outputs after it.
   task automatic drive_cycle(input bit v, input int rs1, input int rs2, input int rd, input bit rd_wen,
                              input bit wen, input int waddr, input logic [DW-1:0] wdata, input bit ordy);
      bit exp_ready, acc;
      logic [DW-1:0] e1, e2;
      bus.in_valid = v; bus.in_rs1 = AW'(rs1); bus.in_rs2 = AW'(rs2);
      bus.in_rd = AW'(rd); bus.in_rd_wen = rd_wen;
      bus.wb_wen = wen; bus.wb_waddr = AW'(waddr); bus.wb_wdata = wdata; bus.out_ready = ordy;
      #1;
      exp_ready  = m_ready(rs1, rs2, rd, rd_wen);
      last_ready = bus.in_ready;
      n_checks++;
      if (bus.in_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL in_ready @%0t: got %b expected %b", $time, bus.in_ready, exp_ready);
      end
      acc = v && exp_ready;
      e1 = m_read(rs1);
      e2 = m_read(rs2);
      @(posedge clk);
      #1;
      if (wen && waddr != 0) begin
         m_pend[waddr] = 1'b0;
         rf[waddr]     = wdata;
      end
      if (acc) begin
         m_valid = 1'b1; m_src1 = e1; m_src2 = e2; m_rd = rd; m_rd_wen = rd_wen;
         if (rd_wen && rd != 0) m_pend[rd] = 1'b1;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      n_checks += 6;
      if (bus.out_valid !== m_valid) begin
         n_fail++; $display("FAIL out_valid @%0t: got %b expected %b", $time, bus.out_valid, m_valid);
      end
      if (bus.out_src1 !== m_src1) begin
         n_fail++; $display("FAIL out_src1 @%0t: got %h expected %h", $time, bus.out_src1, m_src1);
      end
      if (bus.out_src2 !== m_src2) begin
         n_fail++; $display("FAIL out_src2 @%0t: got %h expected %h", $time, bus.out_src2, m_src2);
      end
      if (bus.out_rd !== AW'(m_rd)) begin
         n_fail++; $display("FAIL out_rd @%0t: got %0d expected %0d", $time, bus.out_rd, m_rd);
      end
      if (bus.out_rd_wen !== m_rd_wen) begin
         n_fail++; $display("FAIL out_rd_wen @%0t: got %b expected %b", $time, bus.out_rd_wen, m_rd_wen);
      end
      if (pending !== m_pend_vec()) begin
         n_fail++; $display("FAIL pending @%0t: got %h expected %h", $time, pending, m_pend_vec());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      idle_inputs();
      for (int i = 0; i < NR; i++) rf[i] = {$urandom, $urandom};
      rf[5] = 64'h1234;
      model_reset();
      #2 rst_n = 1'b0;
      #2;
      n_checks += 4;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.out_src1 !== '0 || bus.out_src2 !== '0) begin
         n_fail++; $display("FAIL reset_src: got %h/%h expected 0/0", bus.out_src1, bus.out_src2);
      end
      if (bus.out_rd !== '0 || bus.out_rd_wen !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd: got %0d/%b expected 0/0", bus.out_rd, bus.out_rd_wen);
      end
      if (pending !== '0) begin
         n_fail++; $display("FAIL reset_pending: got %h expected 0", pending);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      drive_cycle(1, 5, 0, 6, 1, 0, 0, '0, 1);
      n_checks += 3;
      if (bus.out_valid !== 1'b1 || bus.out_src1 !== 64'h1234) begin
         n_fail++; $display("FAIL basic_src1: got v=%b %h expected v=1 1234", bus.out_valid, bus.out_src1);
      end
      if (bus.out_src2 !== '0) begin
         n_fail++; $display("FAIL basic_src2: got %h expected 0", bus.out_src2);
      end
      if (pending[6] !== 1'b1) begin
         n_fail++; $display("FAIL basic_pending6: got %b expected 1", pending[6]);
      end
   endtask

   task automatic test_raw();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1, 6, 0, 1, 0, 0, 0, '0, 1);
         n_checks++;
         if (last_ready !== 1'b0) begin
            n_fail++; $display("FAIL raw_stall cycle %0d: in_ready %b expected 0", i, last_ready);
         end
      end
      drive_cycle(1, 6, 0, 1, 0, 1, 6, 64'hABCD, 1);
      n_checks += 2;
      if (last_ready !== 1'b1 || bus.out_src1 !== 64'hABCD) begin
         n_fail++; $display("FAIL raw_bypass: ready %b src1 %h expected 1 abcd", last_ready, bus.out_src1);
      end
      if (pending[6] !== 1'b0) begin
         n_fail++; $display("FAIL raw_clear: pending6 %b expected 0", pending[6]);
      end
   endtask

   task automatic test_waw();
      drive_cycle(1, 0, 0, 7, 1, 0, 0, '0, 1);
      drive_cycle(1, 0, 0, 7, 1, 0, 0, '0, 1);
      n_checks++;
      if (last_ready !== 1'b0) begin
         n_fail++; $display("FAIL waw_stall: in_ready %b expected 0", last_ready);
      end
      drive_cycle(1, 0, 0, 7, 1, 1, 7, 64'h77, 1);
      n_checks += 2;
      if (last_ready !== 1'b1) begin
         n_fail++; $display("FAIL waw_accept: in_ready %b expected 1", last_ready);
      end
      if (pending[7] !== 1'b1) begin
         n_fail++; $display("FAIL waw_set_wins: pending7 %b expected 1", pending[7]);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] hold1, hold2;
      drive_cycle(1, 1, 2, 8, 0, 0, 0, '0, 1);
      hold1 = rf[1];
      hold2 = rf[2];
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1, 3, 4, 9, 0, 0, 0, '0, 0);
         n_checks += 2;
         if (last_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready cycle %0d: got %b expected 0", i, last_ready);
         end
         if (bus.out_src1 !== hold1 || bus.out_src2 !== hold2 || bus.out_rd !== AW'(8)) begin
            n_fail++; $display("FAIL bp_stable cycle %0d: got %h/%h/%0d expected %h/%h/8",
                               i, bus.out_src1, bus.out_src2, bus.out_rd, hold1, hold2);
         end
      end
      drive_cycle(1, 3, 4, 9, 0, 0, 0, '0, 1);
      n_checks += 2;
      if (last_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: in_ready %b expected 1", last_ready);
      end
      if (bus.out_src1 !== rf[3] || bus.out_rd !== AW'(9)) begin
         n_fail++; $display("FAIL bp_next: got %h/%0d expected %h/9", bus.out_src1, bus.out_rd, rf[3]);
      end
   endtask

   task automatic test_x0();
      for (int i = 1; i < NR; i++)
         if (m_pend[i]) drive_cycle(0, 0, 0, 0, 0, 1, i, {$urandom, $urandom}, 1);
      rf[0] = 64'hDEAD_BEEF_0BAD_F00D;
      drive_cycle(1, 0, 0, 0, 1, 1, 0, 64'hFFFF, 1);
      n_checks += 2;
      if (bus.out_src1 !== '0 || bus.out_src2 !== '0) begin
         n_fail++; $display("FAIL x0_read: got %h/%h expected 0/0", bus.out_src1, bus.out_src2);
      end
      if (pending !== '0) begin
         n_fail++; $display("FAIL x0_pending: got %h expected 0", pending);
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(1, 0, 0, 3, 1, 0, 0, '0, 1);
      drive_cycle(1, 3, 0, 4, 0, 0, 0, '0, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks += 2;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL async_out_valid: got %b expected 0", bus.out_valid);
      end
      if (pending !== '0) begin
         n_fail++; $display("FAIL async_pending: got %h expected 0", pending);
      end
      idle_inputs();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_cycle($urandom_range(0, 3) != 0,
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1) != 0,
                     $urandom_range(0, 1) != 0, $urandom_range(0, 7), {$urandom, $urandom},
                     $urandom_range(0, 3) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_raw();
      test_waw();
      test_backpressure();
      test_x0();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22050612_rf_read_stage.md
Name: ysyx_22050612_rf_read_stage

Overview:
- Read-side counterpart of the register file's write port: accepts decoded operand requests, reads the two source operands and captures them into one pipeline register toward execute.
- Takes the register file array as a flattened input bus, with write-back bypass, and a per-register pending-write scoreboard that stalls RAW and WAW hazards.
- Sits between decode and execute; write-back drives the register file write port and this block's wb_* inputs with the same signals.

Parameters:
- ADDR_WIDTH, 5, register index width; NREG = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rf_flat  in  DATA_WIDTH*NREG  register file contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  decode request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_rs1, in_rs2  in  ADDR_WIDTH  source indices.
- in_rd  in  ADDR_WIDTH  destination index.
- in_rd_wen  in  1  instruction will write in_rd.
- wb_wen  in  1  write-back write enable this cycle.
- wb_waddr  in  ADDR_WIDTH  write-back index.
- wb_wdata  in  DATA_WIDTH  write-back data.
- out_valid  out  1  operands valid toward execute.
- out_ready  in  1  execute accepts.
- out_src1, out_src2  out  DATA_WIDTH  captured operands.
- out_rd  out  ADDR_WIDTH  passed-through destination.
- out_rd_wen  out  1  passed-through write enable.
- pending  out  NREG  scoreboard vector, for debug and verification; bit 0 is always 0.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_src1/out_src2=0, out_rd=0, out_rd_wen=0, pending=0. Reset mid-stall drops the held request; the upstream source must re-present it.
- Operand read (combinational, per source s):
  - index 0 gives 0;
  - else, if wb_wen && wb_waddr==s, gives wb_wdata (bypass has priority over rf_flat);
  - else gives the rf_flat slice.
- Bypass rule: writes to x0 never bypass.
- Ready, in order:
  - clear_s = wb_wen && wb_waddr==s.
  - hazard_s = pending[s] && !clear_s, for s in {rs1, rs2}.
  - waw = in_rd_wen && in_rd!=0 && pending[in_rd] && !clear_rd.
  - in_ready = (!out_valid || out_ready) && !hazard_rs1 && !hazard_rs2 && !waw.
  - in_ready is combinational from inputs; it must not depend on in_valid.
- Accept (in_valid && in_ready) at edge N:
  - out_* load the operands and rd fields at edge N; out_valid=1 from cycle N+1 (latency 1);
  - if in_rd_wen && in_rd!=0, pending[in_rd] is set.
- Output handshake:
  - out_valid && out_ready without a new accept: out_valid goes to 0 and data holds.
  - While out_valid && !out_ready: all out_* are stable.
- Scoreboard update each edge:
  - wb_wen && wb_waddr!=0 clears pending[wb_waddr];
  - an accept-set is then applied, so set wins on the same index in the same cycle;
  - pending[0] is hard 0.
- wb to a non-pending register: pending is unchanged, and the bypass still applies.
- Full throughput: one accept per cycle when there are no hazards and out_ready=1.

Decomposition:
- Shared package: ADDR_WIDTH/DATA_WIDTH defaults, NREG, and the x0 index constant, reused by the register file and decode.
- One natural sub-module: ysyx_22050612_scoreboard, which holds the pending vector with set/clear ports and a lookup port for rs1/rs2/rd.
- Operand muxing and the pipeline register stay in the top module.

Test Plan:
- Reset with rf_flat[x5]=0x1234, then request rs1=5, rs2=0, rd=6 wen=1, out_ready=1 -> next cycle out_valid=1, out_src1=0x1234, out_src2=0, pending[6]=1.
- RAW: with pending[6]=1, request rs1=6 -> in_ready=0 for each cycle. Then wb_wen=1, wb_waddr=6, wb_wdata=0xABCD -> accepted that cycle, out_src1=0xABCD (bypass), pending[6]=0.
- WAW with same-cycle set/clear: with pending[7]=1, request rd=7 alongside wb to x7 -> accepted, pending[7] ends at 1.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and out_src1/out_src2/out_rd stable for 3 cycles. out_ready=1 -> the next request is accepted the same cycle.
- x0 cases: wb_wen to x0 with data 0xFFFF, and a request with rs1=0, rd=0, wen=1 -> out_src1=0, pending=0.
- Async reset asserted mid-stall with pending[3]=1 and out_valid=1 -> out_valid=0 and pending=0 immediately, without waiting for a clock edge.
